// File: rtl/pedestal_sub.sv
// pedestal_sub: tracks the ADC baseline with a pulse-guarded windowed average and emits
// baseline-subtracted signed samples (2-clock latency) for the normalising multiplier.
module pedestal_sub #(
   parameter int ADC_BITS = 12,
   parameter int LOG2_WIN = 6,
   parameter int HOLDOFF  = 16,
   parameter int PED_INIT = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [ADC_BITS-1:0]        adc_data,
   input  logic                       invert,
   input  logic                       freeze,
   input  logic [ADC_BITS-1:0]        thr,
   output logic signed [15:0]         dout,
   output logic [ADC_BITS-1:0]        ped,
   output logic                       ped_valid
);
   localparam int HW = $clog2(HOLDOFF + 1);
   localparam int SW = ADC_BITS + LOG2_WIN;
   typedef enum logic [1:0] {INIT, TRACK, GUARD} state_t;
   state_t                   state;
   logic [ADC_BITS-1:0]      raw_r;
   logic                     raw_v;
   logic signed [ADC_BITS:0] diff;
   logic [ADC_BITS:0]        dev;
   logic                     oob, accept, last;
   logic [SW-1:0]            sum, sum_nx;
   logic [LOG2_WIN-1:0]      cnt;
   logic [HW-1:0]            hold;
   assign diff   = $signed({1'b0, raw_r}) - $signed({1'b0, ped});
   assign dev    = diff[ADC_BITS] ? -diff : diff;
   assign oob    = (thr != '0) && (dev > {1'b0, thr});
   // raw_v keeps the empty post-reset stage-1 register out of the first window
   assign accept = raw_v && !freeze && (state == INIT || (state == TRACK && !oob));
   assign last   = accept && (cnt == '1);
   assign sum_nx = sum + {{LOG2_WIN{1'b0}}, raw_r};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw_r     <= '0;
         raw_v     <= 1'b0;
         dout      <= '0;
         ped       <= ADC_BITS'(PED_INIT);
         ped_valid <= 1'b0;
         sum       <= '0;
         cnt       <= '0;
         hold      <= '0;
         state     <= INIT;
      end else begin
         raw_r <= invert ? ~adc_data : adc_data;
         raw_v <= 1'b1;
         dout  <= {{(15 - ADC_BITS){diff[ADC_BITS]}}, diff};
         if (accept) begin
            sum <= last ? '0 : sum_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
               ped       <= sum_nx[SW-1:LOG2_WIN];
               ped_valid <= 1'b1;
               state     <= TRACK;
            end
         end else if (raw_v && !freeze && state == TRACK) begin
            sum   <= '0;
            cnt   <= '0;
            hold  <= HW'(HOLDOFF);
            state <= GUARD;
         end else if (raw_v && !freeze && state == GUARD) begin
            hold <= oob ? HW'(HOLDOFF) : hold - 1'b1;
            if (!oob && hold == HW'(1))
               state <= TRACK;
         end
      end
   end
endmodule
